pipe_stage_reg: RTL

Parametrised pipeline stage register with valid/ready handshake, flush-to-bubble and configurable depth. Successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB): control and data fields are packed into two generic buses, and the block adds back-pressure, bubble insertion and multi-cycle depth. It sits between any two pipeline stages of the MIPS core, with the hazard unit driving `i_flush`.

---
 rtl/pipe_stage_reg.sv | 87 ++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-slot valid/ready pipeline register with flush-to-bubble.
// Optional stall/flush statistics counters are built when PIPE_STAGE_REG_STATS_EN is defined.
module pipe_stage_reg #(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [CTRL_WIDTH-1:0]        i_ctrl,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_flush,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [CTRL_WIDTH-1:0]        o_ctrl,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
  output logic [15:0]                  o_stall_count,
  output logic [15:0]                  o_flush_count
);
  localparam int OCC_W = $clog2(DEPTH+1);
  logic [DEPTH-1:0]                 r_v;
  logic [DEPTH-1:0][CTRL_WIDTH-1:0] r_ctrl;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
  logic [DEPTH-1:0]                 w_adv;
  logic                             w_a;
  logic [OCC_W-1:0]                 w_occ;
  // w_a accumulates the advance condition from the output slot backwards
  always_comb begin
    w_a   = i_ready;
    w_adv = '0;
    w_occ = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      w_a      = w_a | !r_v[k];
      w_adv[k] = w_a;
      w_occ    = w_occ + OCC_W'(r_v[k]);
    end
  end
  assign o_ready     = w_adv[0] & !i_flush;
  assign o_valid     = r_v[DEPTH-1];
  assign o_ctrl      = r_v[DEPTH-1] ? r_ctrl[DEPTH-1] : '0;
  assign o_data      = r_data[DEPTH-1];
  assign o_occupancy = w_occ;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_v    <= '0;
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_flush) begin
      r_v    <= '0;
      r_ctrl <= '0;
    end else begin
      if (w_adv[0]) begin
        r_v[0]    <= i_valid;
        r_ctrl[0] <= i_ctrl;
        r_data[0] <= i_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_adv[k]) begin
          r_v[k]    <= r_v[k-1];
          r_ctrl[k] <= r_ctrl[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end
`ifdef PIPE_STAGE_REG_STATS_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (o_valid && !i_ready && r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'd1;
      if (i_flush && r_flush_count != 16'hFFFF) r_flush_count <= r_flush_count + 16'd1;
    end
  end
  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
`else
  assign o_stall_count = 16'h0000;
  assign o_flush_count = 16'h0000;
`endif
endmodule
